// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Turns the debounced, active-low key level into single-cycle
//               key events: press, release, single click, double click,
//               long press and auto-repeat. Runs entirely in the 1 kHz
//               debounce clock domain and applies no further filtering.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LONG_MS       consecutive low samples that make a long press (2..65535)
//   REPEAT_MS     auto-repeat period while held after a long press (2..65535)
//   DCLICK_MS     max clocks from release to next press for a double click
//                 (2..65535)
// Ports
//   clk_1kHz      in   sample clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   key_state     in   debounced key level, 0 = pressed, 1 = released
//   press_pulse   out  one-clock pulse on every press edge
//   release_pulse out  one-clock pulse on every release edge
//   single_click  out  one-clock pulse when a short press gets no follow-up
//   double_click  out  one-clock pulse on a second press inside the window
//   long_press    out  one-clock pulse when the hold reaches LONG_MS
//   repeat_pulse  out  one-clock pulse every REPEAT_MS clocks in a long hold
//   held          out  level, high while the key is down in a tracked press
// ============================================================================
module key_event_decoder #(
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned DCLICK_MS = 300
) (
    input  logic clk_1kHz,
    input  logic rst_n,
    input  logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DOWN1 = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_DOWN2 = 3'd3,
        ST_LONG  = 3'd4
    } state_t;

    // The hold counter starts at 1 on the press edge, so the long-press
    // decision is taken when it reads LONG_MS-1 (the LONG_MS-th low sample).
    localparam logic [15:0] c_long_last = 16'(LONG_MS - 1);
    localparam logic [15:0] c_repeat    = 16'(REPEAT_MS);
    localparam logic [15:0] c_dclick    = 16'(DCLICK_MS);
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        key_prev_q;
    logic        press_q;
    logic        release_q;
    logic        single_q;
    logic        double_q;
    logic        long_q;
    logic        repeat_q;
    logic        held_q;

    logic        press_edge;
    logic        release_edge;
    logic [15:0] cnt_sat_d;

    // Edges are detected against the previous sample so events appear on the
    // same clock edge that first sees the new level.
    assign press_edge   =  key_prev_q & ~key_state;
    assign release_edge = ~key_prev_q &  key_state;

    // Saturating increment; the counter never wraps back to zero.
    assign cnt_sat_d = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            key_prev_q <= 1'b1;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            key_prev_q <= key_state;

            // Pulses default low; each event below raises one for a cycle.
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            single_q   <= 1'b0;
            double_q   <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (press_edge) begin
                        state_q <= ST_DOWN1;
                        cnt_q   <= 16'd1;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end

                ST_DOWN1: begin
                    if (release_edge) begin
                        state_q   <= ST_WAIT2;
                        cnt_q     <= 16'd1;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == c_long_last) begin
                        state_q <= ST_LONG;
                        cnt_q   <= 16'd1;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                ST_WAIT2: begin
                    // A press in the timeout cycle still wins: checked first.
                    if (press_edge) begin
                        state_q  <= ST_DOWN2;
                        cnt_q    <= 16'd1;
                        press_q  <= 1'b1;
                        double_q <= 1'b1;
                        held_q   <= 1'b1;
                    end else if (cnt_q == c_dclick) begin
                        state_q  <= ST_IDLE;
                        cnt_q    <= 16'd0;
                        single_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                ST_DOWN2: begin
                    // Releasing the second press ends the gesture silently;
                    // the double click was already reported on the press.
                    if (release_edge) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= 16'd0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == c_long_last) begin
                        state_q <= ST_LONG;
                        cnt_q   <= 16'd1;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                ST_LONG: begin
                    if (release_edge) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= 16'd0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == c_repeat) begin
                        cnt_q    <= 16'd1;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 16'd0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Self-checking bench for key_event_decoder. Three instances
//               with different timing parameters share one key stimulus
//               built from directed and random low/high segments. Expected
//               events are derived from the press/release timestamps of the
//               segment list, then compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

    localparam int MAXC  = 40000;
    localparam int NINST = 3;
    localparam int LMS [NINST] = '{1000, 2, 7};
    localparam int RMS [NINST] = '{200, 2, 3};
    localparam int DMS [NINST] = '{300, 2, 4};

    // Observed vector bits per instance
    localparam int B_PRESS  = 0;
    localparam int B_REL    = 1;
    localparam int B_SINGLE = 2;
    localparam int B_DOUBLE = 3;
    localparam int B_LONG   = 4;
    localparam int B_REP    = 5;
    localparam int B_HELD   = 6;

    logic clk_1kHz  = 1'b0;
    logic rst_n     = 1'b0;
    logic key_state = 1'b1;
    logic [NINST-1:0][6:0] obs;

    always #5 clk_1kHz = ~clk_1kHz;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        key_event_decoder #(
            .LONG_MS   (LMS[g]),
            .REPEAT_MS (RMS[g]),
            .DCLICK_MS (DMS[g])
        ) u_dut (
            .clk_1kHz      (clk_1kHz),
            .rst_n         (rst_n),
            .key_state     (key_state),
            .press_pulse   (obs[g][B_PRESS]),
            .release_pulse (obs[g][B_REL]),
            .single_click  (obs[g][B_SINGLE]),
            .double_click  (obs[g][B_DOUBLE]),
            .long_press    (obs[g][B_LONG]),
            .repeat_pulse  (obs[g][B_REP]),
            .held          (obs[g][B_HELD])
        );
    end

    typedef struct {
        int    cyc;
        int    inst;
        int    bitn;
        string tag;
    } spot_t;

    logic       lvl   [MAXC];
    logic [6:0] exp_v [NINST][MAXC];
    int         n_cyc;
    spot_t      spots [$];
    int         n_checks;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, req);
        end
    endtask

    task automatic add_seg(input logic v, input int len);
        for (int i = 0; i < len; i++) begin
            if (n_cyc < MAXC) begin
                lvl[n_cyc] = v;
                n_cyc++;
            end
        end
    endtask

    task automatic add_spot(input int cyc, input int inst, input int bitn, input string tag);
        spot_t s;
        s.cyc  = cyc;
        s.inst = inst;
        s.bitn = bitn;
        s.tag  = tag;
        spots.push_back(s);
    endtask

    task automatic mark(input int k, input int t, input int bitn);
        if (t >= 0 && t < n_cyc) exp_v[k][t][bitn] = 1'b1;
    endtask

    // Expected events from the list of presses: each press is classified by
    // its duration and by the gap to the next press.
    task automatic build_model(input int k);
        int pt [$];
        int rt [$];
        int p, r, lm, rm, dm;
        bit second, nsec;
        lm = LMS[k];
        rm = RMS[k];
        dm = DMS[k];
        for (int c = 0; c < n_cyc; c++) exp_v[k][c] = '0;
        for (int c = 0; c < n_cyc; c++) begin
            if (!lvl[c] && (c == 0 || lvl[c-1])) pt.push_back(c);
            if (lvl[c] && c > 0 && !lvl[c-1])   rt.push_back(c);
        end
        if (rt.size() < pt.size()) rt.push_back(n_cyc);
        second = 1'b0;
        for (int i = 0; i < pt.size(); i++) begin
            p    = pt[i];
            r    = rt[i];
            nsec = 1'b0;
            mark(k, p, B_PRESS);
            mark(k, r, B_REL);
            for (int t = p; t < r; t++) mark(k, t, B_HELD);
            if (r - p >= lm) begin
                mark(k, p + lm - 1, B_LONG);
                for (int t = p + lm - 1 + rm; t < r; t += rm) mark(k, t, B_REP);
            end else if (!second) begin
                if (i + 1 < pt.size() && pt[i+1] - r <= dm) begin
                    mark(k, pt[i+1], B_DOUBLE);
                    nsec = 1'b1;
                end else begin
                    mark(k, r + dm, B_SINGLE);
                end
            end
            second = nsec;
        end
    endtask

    // Must be entered just after a falling edge.
    task automatic run_phase();
        for (int k = 0; k < NINST; k++) build_model(k);
        for (int c = 0; c < n_cyc; c++) begin
            key_state = lvl[c];
            @(posedge clk_1kHz);
            #1;
            for (int k = 0; k < NINST; k++)
                check($sformatf("inst%0d cyc%0d", k, c), 32'(obs[k]), 32'(exp_v[k][c]));
            foreach (spots[s])
                if (spots[s].cyc == c)
                    check(spots[s].tag, 32'(obs[spots[s].inst][spots[s].bitn]), 32'd1);
            @(negedge clk_1kHz);
        end
    endtask

    initial begin
        int t, sel, lo, hi;
        n_checks = 0;
        n_fail   = 0;
        repeat (3) @(negedge clk_1kHz);
        for (int k = 0; k < NINST; k++) check($sformatf("reset_state inst%0d", k), 32'(obs[k]), 32'd0);
        rst_n = 1'b1;

        // Phase A: directed gestures followed by random segments
        n_cyc = 0;
        spots.delete();
        add_seg(1'b1, 5);
        t = n_cyc;
        add_seg(1'b0, 50); add_seg(1'b1, 400);
        add_spot(t, 0, B_PRESS, "sc_press");
        add_spot(t + 50, 0, B_REL, "sc_release");
        add_spot(t + 350, 0, B_SINGLE, "sc_single");
        t = n_cyc;
        add_seg(1'b0, 50); add_seg(1'b1, 100); add_seg(1'b0, 50); add_seg(1'b1, 400);
        add_spot(t + 150, 0, B_DOUBLE, "dc_double");
        add_spot(t + 150, 0, B_PRESS, "dc_press2");
        add_spot(t + 200, 0, B_REL, "dc_release2");
        t = n_cyc;
        add_seg(1'b0, 1500); add_seg(1'b1, 400);
        add_spot(t + 999, 0, B_LONG, "lp_long");
        add_spot(t + 1199, 0, B_REP, "lp_rep1");
        add_spot(t + 1399, 0, B_REP, "lp_rep2");
        add_spot(t + 1500, 0, B_REL, "lp_release");
        t = n_cyc;
        add_seg(1'b0, 50); add_seg(1'b1, 300); add_seg(1'b0, 50); add_seg(1'b1, 400);
        add_spot(t + 350, 0, B_DOUBLE, "win_eq_double");
        t = n_cyc;
        add_seg(1'b0, 50); add_seg(1'b1, 301); add_seg(1'b0, 50); add_seg(1'b1, 400);
        add_spot(t + 350, 0, B_SINGLE, "win_over_single");
        add_spot(t + 351, 0, B_PRESS, "win_over_press");
        add_spot(t + 351, 0, B_HELD, "win_over_held");
        t = n_cyc;
        add_seg(1'b0, 6); add_seg(1'b1, 400);
        add_spot(t + 1, 1, B_LONG, "small_long");
        add_spot(t + 3, 1, B_REP, "small_rep1");
        add_spot(t + 5, 1, B_REP, "small_rep2");
        for (int i = 0; i < 50; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      lo = int'($urandom_range(1, 20));
            else if (sel < 9) lo = int'($urandom_range(21, 400));
            else              lo = int'($urandom_range(990, 1300));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      hi = int'($urandom_range(1, 10));
            else if (sel < 8) hi = int'($urandom_range(250, 350));
            else              hi = int'($urandom_range(1, 400));
            add_seg(1'b0, lo);
            add_seg(1'b1, hi);
        end
        add_seg(1'b1, 400);
        run_phase();

        // Phase B: hold 600 clocks, then reset asynchronously mid-hold
        n_cyc = 0;
        spots.delete();
        add_seg(1'b0, 600);
        run_phase();
        @(posedge clk_1kHz);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NINST; k++) check($sformatf("async_reset inst%0d", k), 32'(obs[k]), 32'd0);
        @(negedge clk_1kHz);
        rst_n = 1'b1;

        // Phase C: key still low when reset releases
        n_cyc = 0;
        spots.delete();
        add_seg(1'b0, 1100); add_seg(1'b1, 400);
        add_spot(0, 0, B_PRESS, "rst_press");
        add_spot(999, 0, B_LONG, "rst_long");
        run_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the debounced, active-low key level produced by the key-scan debouncer and turns it into single-cycle key events: press, release, single click, double click, long press and auto-repeat. It runs entirely in the 1 kHz debounce clock domain and sits between the debouncer and application logic such as menu or counter control. It is a consumer only and applies no further filtering: every level change on `key_state` is treated as genuine.

## Interface
- `LONG_MS`, 1000: consecutive low samples needed to declare a long press. Range 2..65535.
- `REPEAT_MS`, 200: period of `repeat_pulse` while the key is held after a long press. Range 2..65535.
- `DCLICK_MS`, 300: maximum clocks from a release to the next press that still counts as a double click. Range 2..65535.
- `clk_1kHz`  in  1  sample clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_state`  in  1  debounced key level, synchronous to `clk_1kHz`; 0 = pressed, 1 = released.
- `press_pulse`  out  1  one-clock pulse on every press edge.
- `release_pulse`  out  1  one-clock pulse on every release edge.
- `single_click`  out  1  one-clock pulse when a short press is not followed by a second press in time.
- `double_click`  out  1  one-clock pulse on a second press inside the window.
- `long_press`  out  1  one-clock pulse when the hold reaches `LONG_MS`.
- `repeat_pulse`  out  1  one-clock pulse every `REPEAT_MS` clocks during a long hold.
- `held`  out  1  level, high while the FSM is in DOWN1, DOWN2 or LONG.

## Operation
- `key_d` is a register holding the previous sample of `key_state`; it resets to 1.
  - Press edge (pe): `key_d`=1 and `key_state`=0.
  - Release edge (re): `key_d`=0 and `key_state`=1.
- `cnt` is a 16-bit counter that saturates at 0xFFFF and never wraps.
- FSM states: IDLE, DOWN1, WAIT2, DOWN2, LONG. Reset state is IDLE.
- IDLE:
  - On pe: go to DOWN1, set cnt<=1, pulse `press_pulse`.
- DOWN1 (first press, timing the hold):
  - On re: go to WAIT2, set cnt<=1, pulse `release_pulse`.
  - Else, if cnt==LONG_MS-1: go to LONG, set cnt<=1, pulse `long_press`.
  - Else: cnt<=cnt+1.
- WAIT2 (waiting for a second press):
  - On pe: go to DOWN2, pulse `press_pulse` and `double_click` in the same cycle.
  - Else, if cnt==DCLICK_MS: go to IDLE, pulse `single_click`.
  - Else: cnt<=cnt+1.
- DOWN2 (second press):
  - On re: go to IDLE, pulse `release_pulse`. No click event is generated.
  - Else: same long-press logic as DOWN1, going to LONG.
- LONG:
  - On re: go to IDLE, pulse `release_pulse`. No click event is generated.
  - Else, if cnt==REPEAT_MS: pulse `repeat_pulse`, set cnt<=1.
  - Else: cnt<=cnt+1.
- All outputs are registered. Each pulse is high for exactly one `clk_1kHz` period; `held` is a registered level.
- In DOWN1, DOWN2 and LONG, re and the count conditions are mutually exclusive because re implies the key is released.
- In WAIT2, a pe arriving in the same cycle as the timeout (cnt==DCLICK_MS) is resolved in favour of the press: the result is a double click, not a single click.

## Timing
- Reset: all outputs 0, FSM in IDLE, cnt=0, `key_d`=1. Reset is asynchronous, so it takes effect immediately, including mid-hold or mid-window; no events are emitted for the interrupted sequence.
- If the key is already low when reset is released, the first clock edge detects pe and produces `press_pulse`.
- Events on the sampling edge: `press_pulse`/`release_pulse` go high on the same edge that first samples the new level, so there is zero added latency.
- `long_press` rises exactly LONG_MS-1 clocks after `press_pulse`, i.e. on the LONG_MS-th consecutive low sample.
- The first `repeat_pulse` rises REPEAT_MS clocks after `long_press`; later ones follow every REPEAT_MS clocks.
- `single_click` rises exactly DCLICK_MS clocks after `release_pulse`.
- A double click requires pe no later than DCLICK_MS clocks after `release_pulse`; the equal case still counts.
- `held` rises and falls on the same edges as `press_pulse` and `release_pulse`.

## Test plan
- Single click, defaults: key low for 50 clocks, then high.
  - Required: `press_pulse` at t0 and `release_pulse` at t0+50.
  - Required: `single_click` at t0+350; no other events.
- Double click: low 50, high 100, low 50, high.
  - Required: `double_click` together with the second `press_pulse` at t0+150.
  - Required: `release_pulse` at t0+200; no `single_click` anywhere.
- Long hold with repeats: key low for 1500 clocks.
  - Required: `long_press` at t0+999 and `repeat_pulse` at t0+1199 and t0+1399.
  - Required: `release_pulse` at t0+1500; no click events.
- Window boundary: second press exactly 300 clocks after the release → `double_click`. Second press at 301 clocks → `single_click` at 300, then a fresh `press_pulse` with the FSM in DOWN1.
- Reset mid-hold: assert `rst_n`=0 at 600 clocks into a hold. Outputs go to 0 immediately. Release reset with the key still low → `press_pulse` on the first edge, and `long_press` 999 clocks later.
- Small parameters (LONG_MS=2, REPEAT_MS=2, DCLICK_MS=2): hold low 6 clocks. Required: `long_press` at t0+1, `repeat_pulse` at t0+3 and t0+5.
